// File: rtl/int2fp_arbiter.sv
// Two-port arbitrated front end for an integer-to-single-precision converter.
// Define INT2FP_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
`timescale 1ns/1ps
module int2fp_arbiter #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_data,
  input  logic [1:0]       req0_fmt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_data,
  input  logic [1:0]       req1_fmt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_id,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; requesters hold valid/payload until ready, the consumer sees rsp_*
  // held stable while rsp_valid & !rsp_ready.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [31:0]        rsp_data_q, rsp_data_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic               rsp_id_q, rsp_id_d;
  logic               busy_q, busy_d;
  logic               last_grant_q, last_grant_d;
  logic [63:0]        data_q, data_d;
  logic [1:0]         fmt_q, fmt_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               id_q, id_d;

  logic               grant0, grant1, can_accept, accept;
  logic [63:0]        op, mag;
  logic               sign;
  logic [5:0]         lead;
  logic [86:0]        wide;
  logic [22:0]        mant;
  logic [31:0]        conv_res, result;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef INT2FP_ARB_RR_EN
    if (req0_valid && req1_valid) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
`else
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
`endif
    can_accept = (state_q == S_IDLE) || ((state_q == S_RESP) && rsp_ready);
    accept     = can_accept && (grant0 || grant1);
    req0_ready = grant0 && can_accept;
    req1_ready = grant1 && can_accept;
  end

  // Converter: truncating int -> single; a zero operand alone would produce
  // 1.0 here, so the zero override below is what the consumer sees.
  always_comb begin
    case (fmt_q)
      2'b00:   op = {{32{data_q[31]}}, data_q[31:0]};
      2'b01:   op = {32'd0, data_q[31:0]};
      default: op = data_q;
    endcase
    sign = ~fmt_q[0] & op[63];
    mag  = sign ? (~op + 64'd1) : op;
    lead = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (mag[i]) lead = 6'(i);
    end
    wide     = {mag, 23'd0};
    mant     = 23'(wide >> lead);
    conv_res = {sign, 8'd127 + {2'b00, lead}, mant};
    result   = (op == 64'd0) ? 32'h0000_0000 : conv_res;
  end

  always_comb begin
    state_d      = state_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_data_d   = rsp_data_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    data_d       = data_q;
    fmt_d        = fmt_q;
    tag_d        = tag_q;
    id_d         = id_q;
    if (accept) begin
      data_d       = grant1 ? req1_data : req0_data;
      fmt_d        = grant1 ? req1_fmt  : req0_fmt;
      tag_d        = grant1 ? req1_tag  : req0_tag;
      id_d         = grant1;
      last_grant_d = grant1;
    end
    case (state_q)
      S_IDLE: if (accept) state_d = S_CONV;
      S_CONV: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = result;
        rsp_tag_d   = tag_q;
        rsp_id_d    = id_q;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = accept ? S_CONV : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_tag_q    <= '0;
      rsp_id_q     <= 1'b0;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= 64'd0;
      fmt_q        <= 2'b00;
      tag_q        <= '0;
      id_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_id_q     <= rsp_id_d;
      busy_q       <= busy_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      fmt_q        <= fmt_d;
      tag_q        <= tag_d;
      id_q         <= id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_int2fp_arbiter.sv
// Directed bench for int2fp_arbiter: conversions, zero override, arbitration
// order, response backpressure and reset during a conversion.
`timescale 1ns/1ps
module tb_int2fp_arbiter;
  localparam int TAG_W = 5;

  logic             clk, rst_n;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [63:0]      req0_data, req1_data;
  logic [1:0]       req0_fmt, req1_fmt;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic [1:0]       dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [TAG_W-1:0] exp_q[$];

  int2fp_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_fmt(req0_fmt), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_fmt(req1_fmt), .req1_tag(req1_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_id(rsp_id), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic send(input logic p, input logic [1:0] f, input logic [63:0] d,
                      input logic [TAG_W-1:0] t);
    if (p) begin
      req1_valid = 1'b1; req1_fmt = f; req1_data = d; req1_tag = t;
    end else begin
      req0_valid = 1'b1; req0_fmt = f; req0_data = d; req0_tag = t;
    end
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge where the result is presented.
  task automatic single(input string name, input logic p, input logic [1:0] f,
                        input logic [63:0] d, input logic [TAG_W-1:0] t,
                        input logic [31:0] exp);
    send(p, f, d, t);
    #1;
    chk({name, "_rdy"}, 64'(p ? req1_ready : req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    idle();
    chk({name, "_conv"}, 64'({busy, rsp_valid}), 64'b10);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_valid"}, 64'(rsp_valid), 64'd1);
    chk({name, "_data"}, 64'(rsp_data), 64'(exp));
    chk({name, "_tag"}, 64'(rsp_tag), 64'(t));
    chk({name, "_id"}, 64'(rsp_id), 64'(p));
  endtask

  initial begin
    logic [31:0] fvals [4];
    logic [TAG_W-1:0] etag;
    int got, n0, n1;
    logic a0, a1, seen;
    fvals = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_data = '0; req0_fmt = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_data = '0; req1_fmt = '0; req1_tag = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_data", 64'(rsp_data), 64'd0);
    chk("rst_tag_id", 64'({rsp_tag, rsp_id}), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);

    single("s32_neg1",   1'b0, 2'b00, 64'h00000000_FFFFFFFF, 5'd3,  32'hBF800000);
    single("u32_hi_ign", 1'b1, 2'b01, 64'hFFFFFFFF_00000010, 5'd17, 32'h41800000);
    single("u64_msb",    1'b1, 2'b11, 64'h80000000_00000000, 5'd9,  32'h5F000000);
    single("zero64",     1'b0, 2'b10, 64'h0,                 5'd4,  32'h00000000);
    single("s32_zero_hi",1'b0, 2'b00, 64'hFFFFFFFF_00000000, 5'd5,  32'h00000000);
    single("s64_min",    1'b1, 2'b10, 64'h80000000_00000000, 5'd6,  32'hDF000000);
    single("s32_trunc",  1'b0, 2'b00, 64'h00000000_7FFFFFFF, 5'd7,  32'h4EFFFFFF);
    single("u32_msb",    1'b1, 2'b01, 64'h00000000_80000000, 5'd8,  32'h4F000000);
    single("u64_ones",   1'b0, 2'b11, 64'hFFFFFFFF_FFFFFFFF, 5'd1,  32'h5F7FFFFF);
    single("s64_neg1",   1'b1, 2'b10, 64'hFFFFFFFF_FFFFFFFF, 5'd2,  32'hBF800000);
    single("s32_one_hi", 1'b0, 2'b00, 64'hDEADBEEF_00000001, 5'd11, 32'h3F800000);
    @(negedge clk);
    chk("back_to_idle", 64'({busy, dbg_state}), 64'd0);

    // Backpressure: result held while a new port-0 request waits
    rsp_ready = 1'b0;
    send(1'b0, 2'b01, 64'd1, 5'd10);
    @(posedge clk);
    @(negedge clk);
    send(1'b0, 2'b01, 64'd2, 5'd12);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_data", 64'(rsp_data), 64'h3F800000);
      chk("bp_tag_id", 64'({rsp_tag, rsp_id}), 64'({5'd10, 1'b0}));
      chk("bp_readies", 64'({req0_ready, req1_ready}), 64'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 64'(req0_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("bp_conv", 64'({dbg_state, rsp_valid}), 64'({2'd1, 1'b0}));
    chk("bp_tag_held", 64'(rsp_tag), 64'd10);
    @(posedge clk);
    @(negedge clk);
    chk("bp_second_data", 64'(rsp_data), 64'h40000000);
    chk("bp_second_tag", 64'({rsp_valid, rsp_tag}), 64'({1'b1, 5'd12}));
    @(negedge clk);

    // Reset during CONV drops the request
    send(1'b1, 2'b10, 64'd5, 5'd13);
    @(posedge clk);
    @(negedge clk);
    idle();
    chk("rst_mid_conv_state", 64'(dbg_state), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid_busy", 64'({rsp_valid, busy}), 64'd0);
    chk("rst_mid_data", 64'(rsp_data), 64'd0);
    chk("rst_mid_tag", 64'({rsp_tag, rsp_id}), 64'd0);
    chk("rst_mid_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("rst_no_rsp", 64'(seen), 64'd0);

    // Contention: both ports valid with 4 requests each
    for (int k = 0; k < 4; k++) begin
`ifdef INT2FP_ARB_RR_EN
      exp_q.push_back(5'(k));
      exp_q.push_back(5'(16 + k));
`else
      exp_q.push_back(5'(k));
`endif
    end
`ifndef INT2FP_ARB_RR_EN
    for (int k = 0; k < 4; k++) exp_q.push_back(5'(16 + k));
`endif
    got = 0; n0 = 0; n1 = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      if (rsp_valid) begin
        etag = exp_q.pop_front();
        chk("cont_id", 64'(rsp_id), 64'(etag[4]));
        chk("cont_tag", 64'(rsp_tag), 64'(etag));
        chk("cont_data", 64'(rsp_data), 64'(fvals[etag[1:0]]));
        got++;
      end
      req0_valid = (n0 < 4); req0_fmt = 2'b10; req0_data = 64'(n0 + 1); req0_tag = 5'(n0);
      req1_valid = (n1 < 4); req1_fmt = 2'b10; req1_data = 64'(n1 + 1); req1_tag = 5'(16 + n1);
      #1;
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      if (a0) n0++;
      if (a1) n1++;
    end
    idle();
    chk("cont_count", 64'(got), 64'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
